// File: rtl/defines.sv
// Core-wide shared definitions: thread count, execute pipe latencies and the
// thread index type used by every per-thread interface.
`ifndef DEFINES_SV
`define DEFINES_SV

`define THREADS_PER_CORE 4
`define FP_PIPE_LATENCY 5
`define INT_PIPE_LATENCY 1

package defines;
    typedef logic [$clog2(`THREADS_PER_CORE)-1:0] thread_idx_t;
endpackage

`endif

// File: rtl/fp_issue_arbiter_pkg.sv
// Types and helpers for the issue arbiter: pipe selection and the
// writeback-slot index an issued instruction reserves.
package fp_issue_arbiter_pkg;

    localparam int MIN_RESV_SLOT = 1;

    typedef enum logic {
        PIPE_INT = 1'b0,
        PIPE_FP  = 1'b1
    } pipe_sel_e;

    // A reservation made at the issue edge lands one slot below the latency.
    function automatic int resv_slot(input pipe_sel_e pipe, input int fp_lat, input int int_lat);
        return (pipe == PIPE_FP) ? fp_lat - 1 : int_lat - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Reusable round-robin arbiter: one-hot grant starting the search at a
// rotating pointer that moves past the winner when the update enable is set.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_request,
    input  logic               i_update_en,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic               w_found;

    always_comb begin
        w_grant_oh  = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && i_request[w_cand]) begin
                w_found             = 1'b1;
                w_grant_oh[w_cand]  = 1'b1;
                w_grant_idx         = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_update_en) begin
            r_ptr <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    assign o_grant_oh  = w_grant_oh;
    assign o_grant_idx = w_grant_idx;

endmodule

// File: rtl/fp_issue_arbiter.sv
// Per-cycle thread issue arbiter for the shared INT/FP execute datapath; tracks
// future writeback slots so short ops never collide with in-flight FP results.
module fp_issue_arbiter
    import defines::*;
    import fp_issue_arbiter_pkg::*;
#(
    parameter int NUM_THREADS = `THREADS_PER_CORE,
    parameter int FP_LATENCY  = `FP_PIPE_LATENCY,
    parameter int INT_LATENCY = `INT_PIPE_LATENCY
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_THREADS-1:0] ts_request,
    input  logic [NUM_THREADS-1:0] ts_long_latency,
    input  logic [NUM_THREADS-1:0] ts_has_dest,
    input  logic                   wb_rollback_en,
    input  thread_idx_t            wb_rollback_thread_idx,
    output logic [NUM_THREADS-1:0] arb_grant_oh,
    output logic                   arb_grant_valid,
    output thread_idx_t            arb_grant_thread_idx,
    output logic                   arb_grant_long,
    output logic                   arb_wb_conflict
);

    localparam int SLOT_W = $clog2(FP_LATENCY);

    logic [FP_LATENCY-1:1]  r_wb_slot;
    thread_idx_t            r_wb_owner [FP_LATENCY-1:1];
    logic                   r_arb_wb_conflict;

    logic [FP_LATENCY-1:1]  w_slot_shift;
    thread_idx_t            w_owner_shift [FP_LATENCY-1:1];
    logic [FP_LATENCY-1:1]  w_slot_next;
    thread_idx_t            w_owner_next [FP_LATENCY-1:1];

    logic [NUM_THREADS-1:0] w_rolled;
    logic [NUM_THREADS-1:0] w_eligible;
    logic [NUM_THREADS-1:0] w_short_blocked;
    logic [NUM_THREADS-1:0] w_arb_req;
    logic [NUM_THREADS-1:0] w_arb_oh;
    thread_idx_t            w_arb_idx;
    logic                   w_any_grant;
    pipe_sel_e              w_grant_pipe;
    int                     w_resv_int;
    logic [SLOT_W-1:0]      w_resv_slot;
    logic                   w_resv_en;

    // A rolled-back thread sits out this cycle; FP ops always land past the
    // tracked window, so only short ops with a destination can collide.
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
        assign w_rolled[t]        = wb_rollback_en && (wb_rollback_thread_idx == thread_idx_t'(t));
        assign w_short_blocked[t] = !w_rolled[t] && ts_has_dest[t] && !ts_long_latency[t]
                                    && r_wb_slot[INT_LATENCY];
        assign w_eligible[t]      = !w_rolled[t] && !w_short_blocked[t];
    end

    assign w_arb_req = ts_request & w_eligible;

    rr_arbiter #(
        .NUM_REQ (NUM_THREADS),
        .IDX_W   ($bits(thread_idx_t))
    ) u_rr_arbiter (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_request   (w_arb_req),
        .i_update_en (w_any_grant),
        .o_grant_oh  (w_arb_oh),
        .o_grant_idx (w_arb_idx)
    );

    assign w_any_grant  = (|w_arb_oh) && !reset;
    assign w_grant_pipe = ts_long_latency[w_arb_idx] ? PIPE_FP : PIPE_INT;
    assign w_resv_int   = resv_slot(w_grant_pipe, FP_LATENCY, INT_LATENCY);
    assign w_resv_slot  = SLOT_W'(w_resv_int);
    assign w_resv_en    = w_any_grant && ts_has_dest[w_arb_idx] && (w_resv_int >= MIN_RESV_SLOT);

    // Age every reservation by one cycle, dropping those owned by a rolled-back thread.
    for (genvar k = 1; k < FP_LATENCY - 1; k++) begin : g_shift
        assign w_slot_shift[k]  = r_wb_slot[k+1] &&
                                  !(wb_rollback_en && (r_wb_owner[k+1] == wb_rollback_thread_idx));
        assign w_owner_shift[k] = r_wb_owner[k+1];
    end
    assign w_slot_shift[FP_LATENCY-1]  = 1'b0;
    assign w_owner_shift[FP_LATENCY-1] = '0;

    always_comb begin
        w_slot_next  = w_slot_shift;
        w_owner_next = w_owner_shift;
        if (w_resv_en) begin
            w_slot_next[w_resv_slot]  = 1'b1;
            w_owner_next[w_resv_slot] = w_arb_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_slot         <= '0;
            r_wb_owner        <= '{default: '0};
            r_arb_wb_conflict <= 1'b0;
        end else begin
            r_wb_slot         <= w_slot_next;
            r_wb_owner        <= w_owner_next;
            r_arb_wb_conflict <= !w_any_grant && (|(ts_request & w_short_blocked));
        end
    end

    assign arb_grant_oh         = reset ? '0 : w_arb_oh;
    assign arb_grant_valid      = w_any_grant;
    assign arb_grant_thread_idx = w_any_grant ? w_arb_idx : '0;
    assign arb_grant_long       = w_any_grant && ts_long_latency[w_arb_idx];
    assign arb_wb_conflict      = r_arb_wb_conflict;

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Scoreboard bench for fp_issue_arbiter: a reference model that tracks pending
// writebacks by absolute cycle predicts every cycle's grant and conflict flag.
module tb_fp_issue_arbiter;
    import defines::*;

    localparam int N    = 4;
    localparam int FPL  = 5;
    localparam int INTL = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] tsRequest;
    logic [N-1:0] tsLong;
    logic [N-1:0] tsDest;
    logic         rbEn;
    thread_idx_t  rbIdx;
    logic [N-1:0] grantOh;
    logic         grantValid;
    thread_idx_t  grantIdx;
    logic         grantLong;
    logic         wbConflict;

    always #5 clk = ~clk;

    fp_issue_arbiter #(
        .NUM_THREADS (N),
        .FP_LATENCY  (FPL),
        .INT_LATENCY (INTL)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ts_request             (tsRequest),
        .ts_long_latency        (tsLong),
        .ts_has_dest            (tsDest),
        .wb_rollback_en         (rbEn),
        .wb_rollback_thread_idx (rbIdx),
        .arb_grant_oh           (grantOh),
        .arb_grant_valid        (grantValid),
        .arb_grant_thread_idx   (grantIdx),
        .arb_grant_long         (grantLong),
        .arb_wb_conflict        (wbConflict)
    );

    typedef struct {
        logic         valid;
        logic [N-1:0] oh;
        int           idx;
        logic         lng;
        logic         conflict;
    } exp_t;

    typedef struct {
        int due;
        int thr;
    } wb_t;

    exp_t sbq[$];
    wb_t  pend[$];
    int   mPtr      = 0;
    logic mConflict = 1'b0;
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;

    function automatic bit slotBusy(input int due);
        foreach (pend[i]) if (pend[i].due == due) return 1'b1;
        return 1'b0;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lng,
                                 input logic [N-1:0] dst, input logic rbE, input int rbI);
        exp_t e;
        int   g;
        int   t;
        int   lat;
        bit   blockedAny;
        reset     = rst;
        tsRequest = req;
        tsLong    = lng;
        tsDest    = dst;
        rbEn      = rbE;
        rbIdx     = thread_idx_t'(rbI);

        e.valid = 1'b0; e.oh = '0; e.idx = 0; e.lng = 1'b0; e.conflict = mConflict;
        g = -1;
        blockedAny = 1'b0;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                t = (mPtr + i) % N;
                if (req[t] && !(rbE && t == rbI)) begin
                    if (!dst[t] || lng[t] || !slotBusy(cyc + INTL)) begin
                        if (g < 0) g = t;
                    end else begin
                        blockedAny = 1'b1;
                    end
                end
            end
        end
        if (g >= 0) begin
            e.valid = 1'b1; e.oh[g] = 1'b1; e.idx = g; e.lng = lng[g];
        end
        sbq.push_back(e);

        if (rst) begin
            pend.delete();
            mPtr = 0;
            mConflict = 1'b0;
        end else begin
            for (int i = pend.size() - 1; i >= 0; i--)
                if (pend[i].due <= cyc || (rbE && pend[i].thr == rbI)) pend.delete(i);
            if (g >= 0 && dst[g]) begin
                lat = lng[g] ? FPL : INTL;
                if (lat >= 2) pend.push_back('{cyc + lat, g});
            end
            if (g >= 0) mPtr = (g + 1) % N;
            mConflict = (g < 0) && blockedAny;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares the DUT against the oldest prediction mid-cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput("grant_valid", 32'(grantValid), 32'(e.valid));
                checkOutput("grant_oh", 32'(grantOh), 32'(e.oh));
                checkOutput("grant_idx", 32'(grantIdx), e.idx);
                checkOutput("grant_long", 32'(grantLong), 32'(e.lng));
                checkOutput("wb_conflict", 32'(wbConflict), 32'(e.conflict));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int waitCnt;
        reset = 1'b1; tsRequest = '0; tsLong = '0; tsDest = '0; rbEn = 1'b0; rbIdx = '0;
        @(posedge clk);
        #1;

        // Reset with everyone requesting, then plain round-robin.
        repeat (2) applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 0);
        repeat (5) applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 0);

        // FP op from thread 0 blocks thread 1's short op four cycles later.
        applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 0);
        repeat (5) applyStimulus(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 0);
        repeat (4) applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);

        // Same, with a no-dest thread 2 slipping through the blocked cycle.
        applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 0);
        repeat (3) applyStimulus(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 0);
        applyStimulus(1'b0, 4'b0110, 4'b0000, 4'b0010, 1'b0, 0);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 0);
        repeat (4) applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);

        // Rolling back thread 0 frees its slot for thread 1.
        applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
        repeat (2) applyStimulus(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 0);

        // Rollback suppresses the only requester for one cycle.
        applyStimulus(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 0);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 0);

        // Back-to-back FP ops hold two consecutive slots.
        applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 0);
        applyStimulus(1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b0, 0);
        repeat (2) applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
        repeat (3) applyStimulus(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 0);

        // Randomized traffic with occasional reset and rollback.
        for (int c = 0; c < 800; c++) begin
            applyStimulus(logic'($urandom_range(0, 99) < 2), 4'($urandom), 4'($urandom), 4'($urandom),
                          logic'($urandom_range(0, 5) == 0), int'($urandom_range(0, N - 1)));
        end

        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
        waitCnt = 0;
        while (sbq.size() > 0 && waitCnt < 10) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        checkOutput("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_issue_arbiter.md
Name: fp_issue_arbiter

Overview:
- Selects one thread per cycle to issue into the shared execute datapath: either the 1-cycle integer pipe or the 5-stage floating point pipe (fx1..fx5).
- Keeps a writeback-slot reservation vector so a short-latency instruction never reaches writeback in the same cycle as an earlier long-latency FP instruction.
- Sits between the per-thread instruction queues and the execute stages.
- Round-robin fairness; rollback cancels a thread's reservations.

Parameters:
- NUM_THREADS, default `THREADS_PER_CORE (4): number of requesting threads.
- FP_LATENCY, default 5: cycles from issue to writeback, FP pipe.
- INT_LATENCY, default 1: cycles from issue to writeback, integer pipe; must be less than FP_LATENCY.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ts_request  in  NUM_THREADS  thread has an instruction ready to issue.
- ts_long_latency  in  NUM_THREADS  that instruction goes to the FP pipe.
- ts_has_dest  in  NUM_THREADS  that instruction writes a register.
- wb_rollback_en  in  1  rollback this cycle.
- wb_rollback_thread_idx  in  thread_idx_t  thread being rolled back.
- arb_grant_oh  out  NUM_THREADS  one-hot grant (combinational).
- arb_grant_valid  out  1  any grant this cycle.
- arb_grant_thread_idx  out  thread_idx_t  encoded grant.
- arb_grant_long  out  1  granted instruction uses the FP pipe.
- arb_wb_conflict  out  1  registered; previous cycle had an eligible-by-request thread blocked only by a slot conflict.

Behaviour:
- Reservation state: wb_slot[k], k = 1..FP_LATENCY-1. Bit k set means a writeback occurs k cycles after the current cycle. Each slot has a wb_owner[k] thread index.
- Eligibility of requesting thread t:
  - If !ts_has_dest[t]: always eligible.
  - Else if long: eligible if FP_LATENCY > FP_LATENCY-1 slot index (always free).
  - Else short: eligible iff !wb_slot[INT_LATENCY].
  - If wb_rollback_en and t == wb_rollback_thread_idx: never eligible this cycle.
- Grant: combinational within the same cycle.
  - Round-robin among eligible threads, starting at rr_ptr.
  - At most one grant per cycle.
  - While reset is high, all grant outputs are 0.
- Requester handshake: a thread is issued in the cycle its arb_grant_oh bit is high. The requester must update ts_request by the next cycle.
- State update at each clk edge (not in reset):
  - Shift: wb_slot[k] <= wb_slot[k+1], wb_owner[k] <= wb_owner[k+1]; the top slot clears.
  - Reservation: a granted instruction with a destination and latency L sets slot L-1 with owner equal to the granted thread, only if L-1 >= 1. With INT_LATENCY=1, integer issues reserve nothing.
  - Rollback: clears every post-shift slot whose owner equals wb_rollback_thread_idx. A same-cycle grant to a different thread still records its reservation.
  - rr_ptr <= granted index + 1, modulo NUM_THREADS, only on a grant.
  - arb_wb_conflict <= 1 iff a short has_dest request was blocked by wb_slot[INT_LATENCY] and no grant occurred.
- Reset values: wb_slot = 0, wb_owner = 0, rr_ptr = 0, arb_wb_conflict = 0. Reset mid-operation discards all reservations in that cycle.
- No request, or all requesters ineligible: arb_grant_valid=0, arb_grant_oh=0, arb_grant_thread_idx=0, arb_grant_long=0; state still shifts.

Decomposition:
- thread_idx_t and `THREADS_PER_CORE live in defines.sv.
- FP_LATENCY and INT_LATENCY values are added to defines.sv as `FP_PIPE_LATENCY and `INT_PIPE_LATENCY.
- One sub-module: rr_arbiter (NUM_THREADS request, enable-update, one-hot grant plus rotating pointer). It is reusable elsewhere.
- Slot vector and owner shift register stay inline.

Test Plan:
- Reset held 2 cycles with ts_request=4'b1111 -> grant outputs 0. After release, grants cycle through threads 0,1,2,3,0 on consecutive cycles, all short with no dest.
- Thread 0 long with dest granted at cycle N; thread 1 short with dest requests from N+1 -> blocked at cycle N+4 (wb_slot[1] set); arb_wb_conflict=1 at N+5; granted at N+5.
- Same as above, plus thread 2 short without dest requesting at N+4 -> thread 2 granted at N+4; arb_wb_conflict=0 at N+5.
- Thread 0 long with dest at N; wb_rollback_en with thread_idx=0 at N+2 -> thread 1 short with dest is granted at N+4 (slot freed).
- wb_rollback_en for thread 1 while only thread 1 requests -> no grant that cycle; grant the following cycle; rr_ptr unchanged by the suppressed cycle.
- Back-to-back long-with-dest grants from threads 0 and 1 at N, N+1 -> slots 3 and 4 both set at N+2. Short-with-dest blocked at N+4 and N+5, granted at N+6.
